// File: rtl/odd_parity_serial_tx.sv
// rtl/odd_parity_serial_tx.sv - serial frame transmitter with start, LSB-first data, odd parity, stop
module odd_parity_serial_tx #(
  parameter int DATA_W       = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx,
  output logic              busy,
  output logic              parity_bit,
  output logic              frame_done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Counters are sized for the widest legal parameters (255 clocks/bit, 16 data bits).
  localparam logic [7:0] BAUD_LAST = 8'(CLKS_PER_BIT - 1);
  localparam logic [4:0] IDX_LAST  = 5'(DATA_W - 1);

  state_t            state, state_d;
  logic [7:0]        baud, baud_d;
  logic [4:0]        idx, idx_d;
  logic [DATA_W-1:0] shreg, shreg_d;
  logic              tx_d, parity_d, done_d;
  logic              baud_wrap;

  assign baud_wrap = (baud == BAUD_LAST);
  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);

  // Next-state and next-output logic; tx is computed one cycle ahead so it leaves a flop.
  always_comb begin
    state_d  = state;
    baud_d   = baud;
    idx_d    = idx;
    shreg_d  = shreg;
    tx_d     = tx;
    parity_d = parity_bit;
    done_d   = 1'b0;
    if (state != IDLE) begin
      baud_d = baud_wrap ? 8'd0 : baud + 8'd1;
    end
    case (state)
      IDLE: begin
        tx_d   = 1'b1;
        baud_d = 8'd0;
        idx_d  = 5'd0;
        if (in_valid) begin
          state_d  = START;
          shreg_d  = in_data;
          parity_d = ~^in_data;
          tx_d     = 1'b0;
        end
      end
      START: begin
        if (baud_wrap) begin
          // Present data bit 0 and shift so shreg[0] always holds the next bit to send.
          state_d = DATA;
          idx_d   = 5'd0;
          tx_d    = shreg[0];
          shreg_d = shreg >> 1;
        end
      end
      DATA: begin
        if (baud_wrap) begin
          if (idx == IDX_LAST) begin
            state_d = PARITY;
            idx_d   = 5'd0;
            tx_d    = parity_bit;
          end else begin
            idx_d   = idx + 5'd1;
            tx_d    = shreg[0];
            shreg_d = shreg >> 1;
          end
        end
      end
      PARITY: begin
        if (baud_wrap) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        if (baud_wrap) begin
          state_d = IDLE;
          tx_d    = 1'b1;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // State and registered outputs; reset forces the line high immediately and drops the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      baud       <= 8'd0;
      idx        <= 5'd0;
      shreg      <= '0;
      tx         <= 1'b1;
      parity_bit <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_d;
      baud       <= baud_d;
      idx        <= idx_d;
      shreg      <= shreg_d;
      tx         <= tx_d;
      parity_bit <= parity_d;
      frame_done <= done_d;
    end
  end

endmodule

// File: tb/tb_odd_parity_serial_tx.sv
// tb/tb_odd_parity_serial_tx.sv - directed self-checking bench for odd_parity_serial_tx
module tb_odd_parity_serial_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_ready, tx, busy, parity_bit, frame_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int prev_acc = 0;
  logic [6:0] last_obs;

  odd_parity_serial_tx #(.DATA_W(4), .CLKS_PER_BIT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tx         (tx),
    .busy       (busy),
    .parity_bit (parity_bit),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Line value expected at sample k (1..28) after the accept edge: 7 bits of 4 cycles each.
  function automatic logic exp_bit(input logic [3:0] w, input int k);
    int b;
    b = (k - 1) / 4;
    if (b == 0) return 1'b0;
    if (b <= 4) return w[b-1];
    if (b == 5) return ~^w;
    return 1'b1;
  endfunction

  // Called at a negedge: offers w, then checks every cycle of the frame and the done pulse.
  task automatic send(input logic [3:0] w, input bit hold, input int stall_k, input bit check_gap);
    in_data  = w;
    in_valid = 1'b1;
    chk("accept_ready", in_ready, 1);
    @(posedge clk);
    for (int k = 1; k <= 28; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if (check_gap) chk("accept_gap", cyc - prev_acc, 29);
        prev_acc = cyc;
        chk("parity_bit", parity_bit, ~^w);
        if (!hold) in_valid = 1'b0;
      end
      chk($sformatf("tx_w%0h_k%0d", w, k), tx, exp_bit(w, k));
      chk("busy_in_frame", busy, 1);
      chk("ready_in_frame", in_ready, 0);
      chk("done_in_frame", frame_done, 0);
      if (k % 4 == 0) last_obs[k/4-1] = tx;
      if (stall_k != 0 && k == stall_k) begin
        in_data  = 4'b0110;
        in_valid = 1'b1;
      end
      if (stall_k != 0 && k == stall_k + 1) begin
        in_valid = 1'b0;
        in_data  = w;
      end
    end
    @(negedge clk);
    chk("frame_done_pulse", frame_done, 1);
    chk("busy_after", busy, 0);
    chk("ready_after", in_ready, 1);
    chk("tx_idle_after", tx, 1);
    chk("odd_ones", ^last_obs[5:1], 1);
    chk("parity_hold", parity_bit, ~^w);
  endtask

  initial begin
    rst      = 1'b1;
    in_data  = 4'h0;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_parity", parity_bit, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_tx", tx, 1);
    chk("post_rst_busy", busy, 0);

    // Zero word: parity 1, done at edge 28.
    send(4'b0000, 1'b0, 0, 1'b0);
    chk("zero_parity", parity_bit, 1);
    @(negedge clk);
    chk("zero_done_single", frame_done, 0);
    chk("zero_idle_tx", tx, 1);

    // LSB-first order.
    send(4'b1011, 1'b0, 0, 1'b0);
    chk("lsb_first", last_obs[4:1], 4'b1011);
    chk("lsb_parity_line", last_obs[5], 0);
    chk("lsb_parity", parity_bit, 0);
    @(negedge clk);

    // Exhaustive sweep with in_valid held high, accepts 29 cycles apart.
    for (int i = 0; i < 16; i++) begin
      send(4'(i), 1'b1, 0, i != 0);
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("sweep_end_idle", busy, 0);

    // Stall: a word offered mid-frame is ignored.
    send(4'b0011, 1'b0, 10, 1'b0);
    chk("stall_parity_kept", parity_bit, 1);
    @(negedge clk);
    chk("stall_no_accept", busy, 0);
    send(4'b0110, 1'b0, 0, 1'b0);
    chk("stall_next_parity", parity_bit, 1);
    @(negedge clk);

    // Reset during data bit 2 of word 1011 (bit 2 is 0 on the line).
    in_data  = 4'b1011;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (13) @(negedge clk);
    chk("pre_rst_tx_bit2", tx, 0);
    rst = 1'b1;
    #1;
    chk("async_rst_tx", tx, 1);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_ready", in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_hold_done", frame_done, 0);
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("after_abort_done", frame_done, 0);
      chk("after_abort_tx", tx, 1);
    end
    send(4'b1011, 1'b0, 0, 1'b0);
    chk("clean_frame_data", last_obs[4:1], 4'b1011);
    chk("clean_frame_parity", parity_bit, 0);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
